// File: rtl/decode_writeback_if.sv
// Decode/writeback bus: fetch and execute fields in, decoded IDs and operands out.
interface decode_writeback_if;
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        wb_en;
    logic        err;
    logic [3:0]  dbg_sel;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] dbg_val;

    // Upstream side (fetch/execute/memory) driving the stage
    modport master (
        output icode, rA, rB, cnd, valE, valM, wb_en, err, dbg_sel,
        input  srcA, srcB, dstE, dstM, valA, valB, dbg_val
    );

    // The decode/writeback stage itself
    modport slave (
        input  icode, rA, rB, cnd, valE, valM, wb_en, err, dbg_sel,
        output srcA, srcB, dstE, dstM, valA, valB, dbg_val
    );
endinterface

// File: rtl/decode_writeback.sv
// Y86-64 sequential decode/writeback stage with a 15 x 64-bit register file.
module decode_writeback #(
    parameter int         NREG   = 15,
    parameter logic [3:0] RSP_ID = 4'd4
) (
    input  logic         clk,
    input  logic         rst,
    decode_writeback_if.slave bus
);
    localparam logic [3:0] RNONE = 4'hF;

    logic [63:0] regs_q [NREG];
    logic [63:0] regs_d [NREG];
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        wr_ok;

    // Derive source and destination register IDs from the instruction class
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (bus.icode)
            4'd2: begin
                src_a = bus.rA;
                dst_e = bus.cnd ? bus.rB : RNONE;
            end
            4'd3: dst_e = bus.rB;
            4'd4: begin
                src_a = bus.rA;
                src_b = bus.rB;
            end
            4'd5: begin
                src_b = bus.rB;
                dst_m = bus.rA;
            end
            4'd6: begin
                src_a = bus.rA;
                src_b = bus.rB;
                dst_e = bus.rB;
            end
            4'd8: begin
                src_b = RSP_ID;
                dst_e = RSP_ID;
            end
            4'd9: begin
                src_a = RSP_ID;
                src_b = RSP_ID;
                dst_e = RSP_ID;
            end
            4'd10: begin
                src_a = bus.rA;
                src_b = RSP_ID;
                dst_e = RSP_ID;
            end
            4'd11: begin
                src_a = RSP_ID;
                src_b = RSP_ID;
                dst_e = RSP_ID;
                dst_m = bus.rA;
            end
            default: begin
                src_a = RNONE;
            end
        endcase
    end

    assign bus.srcA = src_a;
    assign bus.srcB = src_b;
    assign bus.dstE = dst_e;
    assign bus.dstM = dst_m;

    assign wr_ok = bus.wb_en && !bus.err;

    // Next register file contents; the M write comes last so it wins a dstE == dstM collision
    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            if (dst_e != RNONE && int'(dst_e) < NREG) begin
                regs_d[dst_e] = bus.valE;
            end
            if (dst_m != RNONE && int'(dst_m) < NREG) begin
                regs_d[dst_m] = bus.valM;
            end
        end
    end

    // Register file state; reset overrides any write in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Zero-latency reads with no bypass; RNONE reads as zero
    always_comb begin
        bus.valA    = '0;
        bus.valB    = '0;
        bus.dbg_val = '0;
        if (src_a != RNONE && int'(src_a) < NREG) begin
            bus.valA = regs_q[src_a];
        end
        if (src_b != RNONE && int'(src_b) < NREG) begin
            bus.valB = regs_q[src_b];
        end
        if (bus.dbg_sel != RNONE && int'(bus.dbg_sel) < NREG) begin
            bus.dbg_val = regs_q[bus.dbg_sel];
        end
    end
endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: directed register-file scenarios plus random traffic.
module tb_decode_writeback;
    localparam logic [3:0] F   = 4'hF;
    localparam logic [3:0] RSP = 4'd4;

    logic clk;
    logic rst;
    decode_writeback_if bus ();

    decode_writeback #(.NREG(15), .RSP_ID(4'd4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  src_a;
        logic [3:0]  src_b;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic [63:0] val_a;
        logic [63:0] val_b;
        logic [63:0] dbg;
    } exp_t;

    exp_t        sb [$];
    logic [63:0] model [15];
    int          compared;
    int          mismatched;

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Which register an instruction reads as its first operand
    function automatic logic [3:0] ref_src_a(input logic [3:0] ic, input logic [3:0] ra);
        if (ic == 2 || ic == 4 || ic == 6 || ic == 10) return ra;   // cmov, rmmov, OPq, pushq
        if (ic == 9 || ic == 11) return RSP;                        // ret, popq
        return F;
    endfunction

    function automatic logic [3:0] ref_src_b(input logic [3:0] ic, input logic [3:0] rb);
        if (ic >= 4 && ic <= 6) return rb;                          // rmmov, mrmov, OPq
        if (ic >= 8 && ic <= 11) return RSP;                        // call, ret, push, pop
        return F;
    endfunction

    function automatic logic [3:0] ref_dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic c);
        if (ic == 2) return c ? rb : F;                             // cmov only if taken
        if (ic == 3 || ic == 6) return rb;                          // irmov, OPq
        if (ic >= 8 && ic <= 11) return RSP;                        // stack adjust
        return F;
    endfunction

    function automatic logic [3:0] ref_dst_m(input logic [3:0] ic, input logic [3:0] ra);
        if (ic == 5 || ic == 11) return ra;                         // mrmov, popq
        return F;
    endfunction

    function automatic logic [63:0] ref_read(input logic [3:0] id);
        if (id == F) return 64'h0;
        return model[id];
    endfunction

    // Drive one instruction for one cycle, record expected outputs, then update the model
    task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                                 input logic c, input logic [63:0] ve, input logic [63:0] vm,
                                 input logic we, input logic er, input logic rs, input logic [3:0] dsel);
        exp_t e;
        logic [3:0] de;
        logic [3:0] dm;
        @(posedge clk);
        #1;
        bus.icode = ic;  bus.rA = ra;  bus.rB = rb;  bus.cnd = c;
        bus.valE = ve;   bus.valM = vm; bus.wb_en = we; bus.err = er;
        bus.dbg_sel = dsel;
        rst = rs;
        e.src_a = ref_src_a(ic, ra);
        e.src_b = ref_src_b(ic, rb);
        de      = ref_dst_e(ic, rb, c);
        dm      = ref_dst_m(ic, ra);
        e.dst_e = de;
        e.dst_m = dm;
        e.val_a = ref_read(e.src_a);
        e.val_b = ref_read(e.src_b);
        e.dbg   = ref_read(dsel);
        sb.push_back(e);
        if (rs) begin
            for (int i = 0; i < 15; i++) model[i] = 64'h0;
        end else if (we && !er) begin
            if (de != F) model[de] = ve;
            if (dm != F) model[dm] = vm;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: whenever an expected response is pending, compare it mid-cycle
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("srcA",    {60'h0, bus.srcA}, {60'h0, e.src_a});
            checkOutput("srcB",    {60'h0, bus.srcB}, {60'h0, e.src_b});
            checkOutput("dstE",    {60'h0, bus.dstE}, {60'h0, e.dst_e});
            checkOutput("dstM",    {60'h0, bus.dstM}, {60'h0, e.dst_m});
            checkOutput("valA",    bus.valA,    e.val_a);
            checkOutput("valB",    bus.valB,    e.val_b);
            checkOutput("dbg_val", bus.dbg_val, e.dbg);
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        bus.icode = 4'd1; bus.rA = F; bus.rB = F; bus.cnd = 1'b0;
        bus.valE = '0; bus.valM = '0; bus.wb_en = 1'b0; bus.err = 1'b0; bus.dbg_sel = F;
        for (int i = 0; i < 15; i++) model[i] = 64'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Preload every register, then reset and read them all back as zero
        for (int i = 0; i < 15; i++)
            applyStimulus(4'd3, F, 4'(i), 1'b0, {32'hA5A5_0000, 32'(i + 1)}, 64'h0, 1'b1, 1'b0, 1'b0, 4'(i));
        applyStimulus(4'd1, F, F, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 15; i++)
            applyStimulus(4'd6, 4'(i), 4'(14 - i), 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 4'(i));

        // irmovq $0x1234, %rdx
        applyStimulus(4'd3, F, 4'd2, 1'b0, 64'h1234, 64'h0, 1'b1, 1'b0, 1'b0, 4'd2);
        applyStimulus(4'd1, F, F, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 4'd2);

        // OPq with reg1=5, reg2=7, result 12 into reg2
        applyStimulus(4'd3, F, 4'd1, 1'b0, 64'd5, 64'h0, 1'b1, 1'b0, 1'b0, 4'd1);
        applyStimulus(4'd3, F, 4'd2, 1'b0, 64'd7, 64'h0, 1'b1, 1'b0, 1'b0, 4'd2);
        applyStimulus(4'd6, 4'd1, 4'd2, 1'b0, 64'd12, 64'h0, 1'b1, 1'b0, 1'b0, 4'd2);
        applyStimulus(4'd1, F, F, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 4'd2);

        // cmovxx not taken then taken
        applyStimulus(4'd2, 4'd1, 4'd3, 1'b0, 64'd9, 64'h0, 1'b1, 1'b0, 1'b0, 4'd3);
        applyStimulus(4'd1, F, F, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 4'd3);
        applyStimulus(4'd2, 4'd1, 4'd3, 1'b1, 64'd9, 64'h0, 1'b1, 1'b0, 1'b0, 4'd3);
        applyStimulus(4'd1, F, F, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 4'd3);

        // popq %rsp: memory value wins over the stack adjust
        applyStimulus(4'd3, F, 4'd4, 1'b0, 64'h100, 64'h0, 1'b1, 1'b0, 1'b0, 4'd4);
        applyStimulus(4'd11, 4'd4, F, 1'b0, 64'h108, 64'hDEAD, 1'b1, 1'b0, 1'b0, 4'd4);
        applyStimulus(4'd1, F, F, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 4'd4);

        // Error suppression, invalid icode, and reset colliding with a write
        applyStimulus(4'd3, F, 4'd5, 1'b0, 64'd7, 64'h0, 1'b1, 1'b1, 1'b0, 4'd5);
        applyStimulus(4'd13, 4'd5, 4'd6, 1'b1, 64'h77, 64'h88, 1'b1, 1'b0, 1'b0, 4'd5);
        applyStimulus(4'd1, F, F, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 4'd6);
        applyStimulus(4'd3, F, 4'd6, 1'b0, 64'h55, 64'h0, 1'b1, 1'b0, 1'b1, 4'd6);
        applyStimulus(4'd1, F, F, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 4'd6);

        // Random instruction stream
        for (int n = 0; n < 600; n++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                          {$urandom, $urandom}, {$urandom, $urandom},
                          ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)));
        end

        // Let the monitor drain within a bounded number of cycles
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d responses pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
